// File: rtl/haru_stream_pkg.sv
// Shared definitions for the multi-channel stream stages: FSM state encoding,
// the minimum-one-bit clog2 width helper and the statistics counter width.
package haru_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    localparam int STATS_CNT_WIDTH = 32;

    // A one-entry range still needs a one-bit register.
    function automatic int CLOG2_MIN1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/s2mm_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after
// i_ptr, wrapping modulo NUM_REQ.
module s2mm_rr_arbiter
    import haru_stream_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int PTR_WIDTH = CLOG2_MIN1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [PTR_WIDTH-1:0] i_ptr,
    output logic                 o_found,
    output logic [PTR_WIDTH-1:0] o_index
);

    logic [PTR_WIDTH:0] w_slot;

    // One spare bit keeps ptr+k exact so the wrap is an explicit subtract,
    // which stays correct for non-power-of-two channel counts.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_slot  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_slot = {1'b0, i_ptr} + (PTR_WIDTH+1)'(k);
            if (w_slot >= (PTR_WIDTH+1)'(NUM_REQ)) begin
                w_slot = w_slot - (PTR_WIDTH+1)'(NUM_REQ);
            end
            if (!o_found && i_req[w_slot[PTR_WIDTH-1:0]]) begin
                o_found = 1'b1;
                o_index = w_slot[PTR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/s2mm_packet_arbiter.sv
// Round-robin packet serialiser from NUM_FIFOS FWFT FIFOs onto one AXI Stream,
// tdest = source channel. Optional per-channel packet counters: S2MM_ARB_STATS_EN.
module s2mm_packet_arbiter
    import haru_stream_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_FIFOS       = 2,
    parameter int PACKET_LEN      = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_FIFOS-1:0]                 fifo_empty,
    input  logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_FIFOS-1:0]                 fifo_rden,
    output logic [AXIS_DATA_WIDTH-1:0]           DST_AXIS_tdata,
    output logic [AXIS_DEST_WIDTH-1:0]           DST_AXIS_tdest,
    output logic                                 DST_AXIS_tlast,
    output logic                                 DST_AXIS_tvalid,
    input  logic                                 DST_AXIS_tready
`ifdef S2MM_ARB_STATS_EN
    ,
    output logic [NUM_FIFOS*STATS_CNT_WIDTH-1:0] pkt_count
`endif
);

    localparam int PTR_W = CLOG2_MIN1(NUM_FIFOS);
    localparam int CNT_W = CLOG2_MIN1(PACKET_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKET_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_FIFOS - 1);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic [PTR_W-1:0] r_grant;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_word_cnt;

    logic [AXIS_DATA_WIDTH-1:0] r_tdata;
    logic [AXIS_DEST_WIDTH-1:0] r_tdest;
    logic                       r_tlast;
    logic                       r_tvalid;

    logic [NUM_FIFOS-1:0]       w_req;
    logic                       w_found;
    logic [PTR_W-1:0]           w_index;
    logic                       w_grant_empty;
    logic [FIFO_DATA_WIDTH-1:0] w_head;
    logic                       w_pop;
    logic                       w_last_word;
    logic [PTR_W-1:0]           w_next_ptr;

    assign w_req = ~fifo_empty;

    s2mm_rr_arbiter #(
        .NUM_REQ   (NUM_FIFOS),
        .PTR_WIDTH (PTR_W)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_index (w_index)
    );

    always_comb begin
        w_grant_empty = 1'b1;
        w_head        = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            if (r_grant == PTR_W'(i)) begin
                w_grant_empty = fifo_empty[i];
                w_head        = fifo_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            end
        end
    end

    // Pop only into an empty or simultaneously-drained output register.
    assign w_pop       = (r_state == SEND) && !w_grant_empty && (!r_tvalid || DST_AXIS_tready);
    assign w_last_word = (r_word_cnt == LAST_IDX);
    assign w_next_ptr  = (r_grant == LAST_CH) ? '0 : r_grant + PTR_W'(1);

    always_comb begin
        fifo_rden = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            if (w_pop && (r_grant == PTR_W'(i))) begin
                fifo_rden[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_pop && w_last_word) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_word_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_found) begin
                r_grant    <= w_index;
                r_word_cnt <= '0;
            end
        end else if (w_pop) begin
            if (w_last_word) begin
                r_word_cnt <= '0;
                r_rr_ptr   <= w_next_ptr;
            end else begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tdata  <= '0;
            r_tdest  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (w_pop) begin
            r_tdata  <= AXIS_DATA_WIDTH'(w_head);
            r_tdest  <= AXIS_DEST_WIDTH'(r_grant);
            r_tlast  <= w_last_word;
            r_tvalid <= 1'b1;
        end else if (DST_AXIS_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign DST_AXIS_tdata  = r_tdata;
    assign DST_AXIS_tdest  = r_tdest;
    assign DST_AXIS_tlast  = r_tlast;
    assign DST_AXIS_tvalid = r_tvalid;

`ifdef S2MM_ARB_STATS_EN
    logic [STATS_CNT_WIDTH-1:0] r_pkt_cnt [NUM_FIFOS];
    logic                       w_pkt_done;

    // Counted on the accepted tlast beat, not on the final pop.
    assign w_pkt_done = r_tvalid && DST_AXIS_tready && r_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else if (w_pkt_done) begin
            for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
                if (r_tdest == AXIS_DEST_WIDTH'(i)) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + STATS_CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            pkt_count[i*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] = r_pkt_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Directed bench for s2mm_packet_arbiter (2 channels, 4-word packets) with
// queue-backed FWFT FIFO models; stats checks when S2MM_ARB_STATS_EN is defined.
module tb_s2mm_packet_arbiter;

    localparam int NF   = 2;
    localparam int PL   = 4;
    localparam int AW   = 32;
    localparam int FW   = 32;
    localparam int DSTW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NF-1:0]   fifo_empty;
    logic [NF*FW-1:0] fifo_data;
    logic [NF-1:0]   fifo_rden;
    logic [AW-1:0]   DST_AXIS_tdata;
    logic [DSTW-1:0] DST_AXIS_tdest;
    logic            DST_AXIS_tlast;
    logic            DST_AXIS_tvalid;
    logic            DST_AXIS_tready;
`ifdef S2MM_ARB_STATS_EN
    logic [NF*32-1:0] pkt_count;
`endif

    always #5 clk = ~clk;

    s2mm_packet_arbiter #(
        .AXIS_DATA_WIDTH (AW),
        .FIFO_DATA_WIDTH (FW),
        .AXIS_DEST_WIDTH (DSTW),
        .NUM_FIFOS       (NF),
        .PACKET_LEN      (PL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_empty      (fifo_empty),
        .fifo_data       (fifo_data),
        .fifo_rden       (fifo_rden),
        .DST_AXIS_tdata  (DST_AXIS_tdata),
        .DST_AXIS_tdest  (DST_AXIS_tdest),
        .DST_AXIS_tlast  (DST_AXIS_tlast),
        .DST_AXIS_tvalid (DST_AXIS_tvalid),
        .DST_AXIS_tready (DST_AXIS_tready)
`ifdef S2MM_ARB_STATS_EN
        ,
        .pkt_count       (pkt_count)
`endif
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  dest;
        logic        last;
        logic [31:0] cyc;
    } beat_t;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    beat_t       beats[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          first_valid = -1;
    logic [1:0]  pend;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [3:0]  prev_dest;
    logic [31:0] pat = 32'hB3A5_6C9D;
    int          bi = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty[0]    = (q0.size() == 0);
        fifo_empty[1]    = (q1.size() == 0);
        fifo_data[31:0]  = (q0.size() != 0) ? q0[0] : 32'h0;
        fifo_data[63:32] = (q1.size() != 0) ? q1[0] : 32'h0;
    endtask

    // Sample just after the negedge stimulus settles, then apply pops after the edge.
    task automatic cycle();
        beat_t b;
        #1;
        pend = fifo_rden;
        if (!rst && DST_AXIS_tvalid && first_valid < 0) first_valid = cyc;
        if (prev_stall && !rst) begin
            check("hold_valid", DST_AXIS_tvalid, 1);
            check("hold_data", DST_AXIS_tdata, prev_data);
            check("hold_last", DST_AXIS_tlast, prev_last);
            check("hold_dest", DST_AXIS_tdest, prev_dest);
        end
        if (!rst && DST_AXIS_tvalid && DST_AXIS_tready) begin
            b.d    = DST_AXIS_tdata;
            b.dest = DST_AXIS_tdest;
            b.last = DST_AXIS_tlast;
            b.cyc  = cyc;
            beats.push_back(b);
        end
        prev_stall = !rst && DST_AXIS_tvalid && !DST_AXIS_tready;
        prev_data  = DST_AXIS_tdata;
        prev_last  = DST_AXIS_tlast;
        prev_dest  = DST_AXIS_tdest;
        @(posedge clk);
        #1;
        if (pend[0]) begin
            check("pop0_nonempty", q0.size() != 0, 1);
            if (q0.size() != 0) void'(q0.pop_front());
        end
        if (pend[1]) begin
            check("pop1_nonempty", q1.size() != 0, 1);
            if (q1.size() != 0) void'(q1.pop_front());
        end
        cyc++;
        refresh();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        DST_AXIS_tready = 1'b1;
        refresh();
        cycle();
        cycle();
        rst = 1'b0;
        beats.delete();
        first_valid = -1;
        prev_stall  = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input bit bp, input string tag);
        int g = 0;
        while (beats.size() < n && g < budget) begin
            if (bp) begin
                DST_AXIS_tready = pat[bi];
                bi = (bi + 1) % 32;
            end
            cycle();
            g++;
        end
        DST_AXIS_tready = 1'b1;
        check({tag, "_beats"}, beats.size(), n);
    endtask

    task automatic check_pkt(input int idx, input logic [31:0] base, input logic [3:0] dest, input string tag);
        for (int k = 0; k < PL; k++) begin
            if (idx + k < beats.size()) begin
                check($sformatf("%s_data%0d", tag, k), beats[idx+k].d, base + k);
                check($sformatf("%s_dest%0d", tag, k), beats[idx+k].dest, dest);
                check($sformatf("%s_last%0d", tag, k), beats[idx+k].last, (k == PL-1));
            end
        end
    endtask

    task automatic load(input int ch, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            if (ch == 0) q0.push_back(base + k);
            else         q1.push_back(base + k);
        end
        refresh();
    endtask

    initial begin
        int c0;
        int g;
        rst = 1'b1;
        DST_AXIS_tready = 1'b1;
        refresh();

        // Reset values, with data pending so a stray grant or pop would show.
        load(0, 32'h0000_0055, 4);
        cycle();
        cycle();
        check("rst_tvalid", DST_AXIS_tvalid, 0);
        check("rst_tlast", DST_AXIS_tlast, 0);
        check("rst_tdata", DST_AXIS_tdata, 0);
        check("rst_tdest", DST_AXIS_tdest, 0);
        check("rst_rden", fifo_rden, 0);

        // Single channel, latency and tlast placement.
        do_reset();
        c0 = cyc;
        load(1, 32'hA0, 4);
        run_until(4, 40, 0, "single");
        check("single_latency", first_valid, c0 + 2);
        check_pkt(0, 32'hA0, 1, "single");
        check("single_drained", q1.size(), 0);

        // Round-robin over three packets per channel.
        do_reset();
        load(0, 32'h100, 12);
        load(1, 32'h200, 12);
        run_until(24, 200, 0, "rr");
        for (int p = 0; p < 6; p++) begin
            check_pkt(p*4, ((p % 2) == 0 ? 32'h100 : 32'h200) + 32'((p / 2) * 4), 4'(p % 2), $sformatf("rr_p%0d", p));
        end
        for (int i = 1; i < 24; i++) begin
            if (i < beats.size()) begin
                check($sformatf("rr_gap%0d", i), beats[i].cyc - beats[i-1].cyc, ((i % 4) == 0) ? 2 : 1);
            end
        end

        // Backpressure from a fixed tready pattern.
        do_reset();
        load(0, 32'h300, 8);
        load(1, 32'h400, 4);
        run_until(12, 400, 1, "bp");
        check_pkt(0, 32'h300, 0, "bp_a");
        check_pkt(4, 32'h400, 1, "bp_b");
        check_pkt(8, 32'h304, 0, "bp_c");

        // Starvation: channel 0 runs dry mid-packet while channel 1 waits.
        do_reset();
        load(0, 32'h500, 2);
        load(1, 32'h600, 4);
        g = 0;
        while (q0.size() != 0 && g < 20) begin
            cycle();
            g++;
        end
        check("starve_drain", q0.size(), 0);
        for (int i = 0; i < 5; i++) cycle();
        check("starve_idle_valid", DST_AXIS_tvalid, 0);
        load(0, 32'h502, 2);
        run_until(8, 100, 0, "starve");
        check_pkt(0, 32'h500, 0, "starve_a");
        check_pkt(4, 32'h600, 1, "starve_b");
        if (beats.size() >= 3) check("starve_gap", (beats[2].cyc - beats[1].cyc) > 1, 1);

        // Reset after word 1 of the second channel-0 packet (rr_ptr is 1 there).
        do_reset();
        load(0, 32'h6F0, 4);
        load(0, 32'h700, 4);
        run_until(5, 40, 0, "rstmid_pre");
        if (beats.size() >= 5) check("rstmid_pre_last", beats[4].last, 0);
        rst = 1'b1;
        q0.delete();
        refresh();
        cycle();
        check("rstmid_tvalid", DST_AXIS_tvalid, 0);
        check("rstmid_tlast", DST_AXIS_tlast, 0);
        check("rstmid_tdata", DST_AXIS_tdata, 0);
        check("rstmid_tdest", DST_AXIS_tdest, 0);
        check("rstmid_rden", fifo_rden, 0);
        cycle();
        rst = 1'b0;
        beats.delete();
        prev_stall = 1'b0;
        load(0, 32'h710, 4);
        load(1, 32'h800, 4);
        run_until(8, 100, 0, "rstmid_post");
        check_pkt(0, 32'h710, 0, "rstmid_a");
        check_pkt(4, 32'h800, 1, "rstmid_b");

`ifdef S2MM_ARB_STATS_EN
        begin
            logic [63:0] snap;
            bit held = 1'b0;
            do_reset();
            load(0, 32'h900, 12);
            load(1, 32'hA00, 4);
            g = 0;
            while (beats.size() < 16 && g < 300) begin
                if (!held && DST_AXIS_tvalid && DST_AXIS_tlast) begin
                    DST_AXIS_tready = 1'b0;
                    snap = pkt_count;
                    for (int i = 0; i < 3; i++) begin
                        cycle();
                        check($sformatf("stats_hold%0d", i), pkt_count, snap);
                    end
                    DST_AXIS_tready = 1'b1;
                    held = 1'b1;
                end
                cycle();
                g++;
            end
            cycle();
            check("stats_beats", beats.size(), 16);
            check("stats_ch0", pkt_count[31:0], 3);
            check("stats_ch1", pkt_count[63:32], 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/s2mm_packet_arbiter.md
# s2mm_packet_arbiter

Return-path counterpart to the MM2S packet filter. Collects fixed-length result packets from `NUM_FIFOS` accelerator output FIFOs and serialises them onto one AXI Stream toward the slave S2MM port of the MCDMA. Each packet carries its source FIFO index on `tdest`, which the MCDMA uses to select the S2MM channel. Channels are granted round-robin, and a granted channel keeps the grant until its whole packet has been sent, so packets never interleave.

## Interface
- `AXIS_DATA_WIDTH`, 32, output stream data width; must be ≥ `FIFO_DATA_WIDTH`.
- `FIFO_DATA_WIDTH`, 32, width of each source FIFO word.
- `AXIS_DEST_WIDTH`, 4, `tdest` width; `NUM_FIFOS` ≤ 2**`AXIS_DEST_WIDTH`.
- `NUM_FIFOS`, 2, number of source FIFOs.
- `PACKET_LEN`, 256, words per packet; must be ≥ 1.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  `NUM_FIFOS`  source FIFO empty flags; FIFOs are first-word-fall-through.
- `fifo_data`  in  `NUM_FIFOS*FIFO_DATA_WIDTH`  flattened FIFO heads; channel i occupies bits [i*W +: W].
- `fifo_rden`  out  `NUM_FIFOS`  pop strobe, one-hot or zero.
- `DST_AXIS_tdata`  out  `AXIS_DATA_WIDTH`  FIFO word, zero-extended to the stream width.
- `DST_AXIS_tdest`  out  `AXIS_DEST_WIDTH`  index of the granted channel.
- `DST_AXIS_tlast`  out  1  marks the last word of a packet.
- `DST_AXIS_tvalid`  out  1  output register holds a word.
- `DST_AXIS_tready`  in  1  downstream accept.

## Operation
- FSM states are `IDLE` and `SEND`.
- **`IDLE`**
  - Search channels starting at `rr_ptr`, wrapping modulo `NUM_FIFOS`, for the first channel with `!fifo_empty`.
  - If one is found, register `grant` = that index, set `word_cnt` = 0 and go to `SEND`.
  - If all channels are empty, stay in `IDLE`.
- **`SEND` pop condition:** `pop = !fifo_empty[grant] && (!DST_AXIS_tvalid || DST_AXIS_tready)`.
  - On pop, `fifo_rden[grant]` = 1 combinationally.
  - The output register loads `tdata` = `fifo_data[grant]`, `tdest` = `grant`, and `tlast` = (`word_cnt` == `PACKET_LEN`-1).
  - `word_cnt` increments.
- **End of packet:** on the pop where `word_cnt` == `PACKET_LEN`-1, set `rr_ptr` = (`grant`+1) mod `NUM_FIFOS` and return to `IDLE`.
- **Granted FIFO runs empty mid-packet:** no pop occurs and the grant is held. `tvalid` drops once the register drains. Switching channels mid-packet is forbidden.
- **Output register:** `tvalid` is set on pop. It clears when `tready` is high and no pop occurs in the same cycle. While `tvalid && !tready`, `tdata`/`tdest`/`tlast` are held stable.
- **Arithmetic:** `word_cnt` and `rr_ptr` use $clog2 widths with minimum width 1. `rr_ptr` wraps explicitly and is not wrapped by power-of-two overflow.
- **`fifo_rden` outside `SEND`:** always 0; a pop is never issued on an empty FIFO.

## Timing
- **Reset values**
  - All outputs 0: `fifo_rden`, `tdata`, `tdest`, `tlast`, `tvalid`.
  - Internal state: `IDLE`, `rr_ptr` = 0, `grant` = 0, `word_cnt` = 0.
- **Latency:** when `fifo_empty` falls in `IDLE` (cycle 0), the grant is registered in cycle 0, the first pop happens in cycle 1, and `tvalid` is first high in cycle 2.
- **Throughput:** one word per cycle while the FIFO is non-empty and `tready` is high.
- **Packet gap:** exactly one `IDLE` bubble cycle between consecutive packets.
- **Reset mid-packet:** the partial packet is abandoned with no `tlast` emitted. Words already popped are lost. The next packet restarts the count from 0.
- **Simultaneous pop and accept with `tvalid` high:** the register is replaced with no bubble.

## Configuration
- The only compile-time option is `S2MM_ARB_STATS_EN`.
- **Defined:** adds output port `pkt_count`, `NUM_FIFOS*32` bits wide, flattened per channel.
  - Channel i's counter increments on its `tlast` handshake (`tvalid && tready && tlast`), counting on accepted packets rather than pops.
  - Counters wrap at 2^32 and reset to 0.
- **Undefined:** the port and counters are absent; the module is otherwise cycle-identical.

## Structure
- **Shared package `haru_stream_pkg`:**
  - the FSM state enum (`IDLE`, `SEND`);
  - a `CLOG2_MIN1` width helper;
  - the `STATS_CNT_WIDTH` = 32 constant.
- **Sub-module `s2mm_rr_arbiter`:** purely combinational.
  - Inputs: request vector (`~fifo_empty`) and `rr_ptr`.
  - Outputs: `found` and `index`.
  - Instantiated once and reusable by other multi-channel stages.

## Test plan
- **Single channel:** `PACKET_LEN`=4; channel 1 holds 0xA0–0xA3; `tready`=1.
  - Required: 4 beats, `tdest`=1, `tlast` only on 0xA3, first `tvalid` 2 cycles after `fifo_empty[1]` falls.
- **Round-robin:** both channels hold 3 packets each.
  - Required: `tdest` sequence 0,1,0,1,0,1 with no interleaving inside a packet, and exactly one bubble between packets.
- **Backpressure:** `tready` toggled pseudo-randomly.
  - Required: words in FIFO order, and `tdata`/`tlast` unchanged across every `tvalid && !tready` cycle.
- **Starvation:** channel 0 goes empty after word 2 of 4 for 5 cycles while channel 1 is non-empty.
  - Required: `tvalid` drops, channel 0 finishes its packet, `tdest` never shows 1 mid-packet.
- **Reset mid-packet:** `rst` asserted after word 1 of 4.
  - Required: all outputs 0 the next cycle; the next packet starts from channel 0 with a full 4 words and `tlast` on word 4.
- **Stats (with `S2MM_ARB_STATS_EN`):** 3 packets on channel 0, 1 packet on channel 1.
  - Required: `pkt_count` channel 0 = 3, channel 1 = 1; the counts do not change while `tlast` is held unaccepted.
